// File: rtl/mem_burst_sram_pkg.sv
// Purpose  : shared types and helpers for the burst SRAM block.
// Latency  : n/a (package only).
// Backpres.: n/a.
// Contents : FSM state enum, byte-offset helper, upper bound on read pipeline depth.
package mem_burst_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int MAX_READ_LATENCY = 4;

  // Number of byte-address bits that select a byte inside one word.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_burst_sram_if.sv
// Purpose  : request / write-beat / read-data bundle between a bus master and the burst SRAM.
// Latency  : n/a (wiring only).
// Backpres.: req_ready_o throttles requests, wready_o throttles write beats; read data has none.
// Ports    : req_* request channel, w* write beat channel, r* read return, err_o reject pulse.
interface mem_burst_sram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 5
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_W/8-1:0]   req_be_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [LEN_W-1:0]      req_len_i;
  logic                  wvalid_i;
  logic                  wready_o;
  logic [DATA_W-1:0]     wdata_i;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  err_o;

  modport slave (
    input  req_valid_i, req_be_i, req_addr_i, req_len_i, wvalid_i, wdata_i,
    output req_ready_o, wready_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output req_valid_i, req_be_i, req_addr_i, req_len_i, wvalid_i, wdata_i,
    input  req_ready_o, wready_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/mem_burst_sram_rd_pipe.sv
// Purpose  : read-return pipeline; stage 0 captures the array word, later stages add delay.
// Latency  : READ_LATENCY cycles from i_vld to o_vld.
// Backpres.: none; a beat entering always leaves READ_LATENCY cycles later.
// Ports    : i_vld/i_dat issued beat, o_vld/o_dat returned beat, o_busy any beat in flight.
module mem_burst_sram_rd_pipe
  import mem_burst_sram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_busy
);

  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]       r_dat [READ_LATENCY];

  // Data registers only load alongside a valid beat, so the output holds
  // the last returned word while o_vld is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_dat[s] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_dat[0] <= i_dat;
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_dat[s] <= r_dat[s-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[READ_LATENCY-1];
  assign o_dat  = r_dat[READ_LATENCY-1];
  assign o_busy = |r_vld;

endmodule

// File: rtl/mem_burst_sram.sv
// Purpose  : single-port word SRAM with byte-lane writes and incrementing bursts.
// Latency  : read beat issued at cycle t returns at t+READ_LATENCY; one beat per cycle.
// Backpres.: req_ready_o only in IDLE; wready_o only in WRITE; read return cannot be stalled.
// Ports    : clk_i, rst_ni (async active-low), bus = slave side of mem_burst_sram_if.
module mem_burst_sram
  import mem_burst_sram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16384,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mem_burst_sram_if.slave    bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = off_bits(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BURST);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [BYTES-1:0]   r_be;
  logic [IDX_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_rem;
  logic               r_err;

  logic               w_req_ready;
  logic               w_wready;
  logic               w_issue;
  logic               w_accept;
  logic               w_bad;
  logic               w_wbeat;
  logic               w_pipe_busy;
  logic               w_rvalid;
  logic [DATA_W-1:0]  w_rdata;
  logic [DATA_W-1:0]  w_mem_rdat;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  // Request check. DEPTH is a power of two, so "addr >= MEM_BYTES" is just
  // "any bit above the word-index field is set".
  assign w_bad = (|(bus.req_addr_i & OFF_MASK))
              || ((bus.req_addr_i >> (OFF_W + IDX_W)) != '0)
              || (bus.req_len_i == '0)
              || (bus.req_len_i > LEN_MAX);

  assign w_accept = bus.req_valid_i & w_req_ready;
  assign w_wbeat  = bus.wvalid_i & w_wready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_wready    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by reset so the requester never sees ready while held in reset.
        w_req_ready = rst_ni;
        if (bus.req_valid_i && rst_ni && !w_bad) begin
          w_state_nxt = (bus.req_be_i != '0) ? WRITE : READ;
        end
      end
      WRITE: begin
        w_wready = 1'b1;
        if (bus.wvalid_i && (r_rem == LEN_W'(1))) begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        w_issue = 1'b1;
        if (r_rem == LEN_W'(1)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Holding off new requests until the pipe empties keeps one burst's
        // return beats contiguous and separate from the next burst.
        if (!w_pipe_busy) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_be    <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        r_be  <= bus.req_be_i;
        r_idx <= IDX_W'(bus.req_addr_i >> OFF_W);
        r_rem <= bus.req_len_i;
      end else if (w_wbeat || w_issue) begin
        // Index width equals log2(DEPTH), so the increment wraps to word 0 for free.
        r_idx <= r_idx + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_wbeat) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign w_mem_rdat = r_mem[r_idx];

  mem_burst_sram_rd_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_vld  (w_issue),
    .i_dat  (w_mem_rdat),
    .o_vld  (w_rvalid),
    .o_dat  (w_rdata),
    .o_busy (w_pipe_busy)
  );

  assign bus.req_ready_o = w_req_ready;
  assign bus.wready_o    = w_wready;
  assign bus.rvalid_o    = w_rvalid;
  assign bus.rdata_o     = w_rdata;
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_mem_burst_sram.sv
// Purpose  : directed self-checking bench for mem_burst_sram (32-bit, 16384 words, read latency 2).
// Latency  : expects read data two cycles after the beat is issued.
// Backpres.: bench waits on req_ready_o / wready_o with bounded loops.
module tb_mem_burst_sram;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16384;
  localparam int ADDR_W = 32;
  localparam int RL     = 2;
  localparam int MB     = 16;
  localparam int LEN_W  = 5;

  localparam logic [31:0] WORD_A = 32'hA5A5_0001;
  localparam logic [31:0] WORD_B = 32'h5A5A_0002;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mem_burst_sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mem_burst_sram #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (RL),
    .MAX_BURST    (MB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns one cycle after the accepting edge.
  task automatic issue_req(input logic [31:0] addr, input logic [3:0] be, input logic [4:0] len);
    int n = 0;
    bus.req_addr_i  = addr;
    bus.req_be_i    = be;
    bus.req_len_i   = len;
    bus.req_valid_i = 1'b1;
    while (bus.req_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL req_accept_timeout addr=%h got ready=%b want 1", addr, bus.req_ready_o);
    end
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic write_beats(input logic [31:0] d [16], input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int k = 0;
      bus.wvalid_i = 1'b1;
      bus.wdata_i  = d[i];
      while (bus.wready_o !== 1'b1 && k < 50) begin
        step();
        k++;
      end
      vectors++;
      if (k >= 50) begin
        miscompares++;
        $display("FAIL wready_timeout beat=%0d got wready=%b want 1", i, bus.wready_o);
      end
      step();
      bus.wvalid_i = 1'b0;
    end
  endtask

  // Issue a read burst and capture every returned beat with the cycle it appeared in.
  task automatic read_burst(input logic [31:0] addr, input logic [4:0] len,
                            output logic [31:0] got [16], output int ngot,
                            output int first_k, output bit contig);
    int last_k = -1;
    for (int i = 0; i < 16; i++) got[i] = '0;
    ngot    = 0;
    first_k = -1;
    contig  = 1'b1;
    issue_req(addr, 4'h0, len);
    for (int k = 1; k <= int'(len) + 8; k++) begin
      step();
      if (bus.rvalid_o === 1'b1) begin
        if (ngot < 16) got[ngot] = bus.rdata_o;
        if (first_k < 0) first_k = k;
        else if (k != last_k + 1) contig = 1'b0;
        last_k = k;
        ngot++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want 0", bus.req_ready_o); end
    vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got=%b want 0", bus.rvalid_o); end
    vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b want 0", bus.err_o); end
    vectors++; if (bus.wready_o !== 1'b0) begin miscompares++; $display("FAIL rst_wready got=%b want 0", bus.wready_o); end
    vectors++; if (bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got=%h want 0", bus.rdata_o); end
    rst_n = 1'b1;
    step();
    vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got=%b want 1", bus.req_ready_o); end
    vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_rvalid got=%b want 0", bus.rvalid_o); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d [16];
    for (int i = 0; i < 16; i++) d[i] = '0;
    d[0] = 32'hDEAD_BEEF;
    issue_req(32'h100, 4'b1111, 5'd1);
    write_beats(d, 0, 1);
    d[0] = 32'h0000_AA00;
    issue_req(32'h100, 4'b0010, 5'd1);
    write_beats(d, 0, 1);
    issue_req(32'h100, 4'b0000, 5'd1);
    step();
    vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL lane_rvalid_early got=%b want 0", bus.rvalid_o); end
    step();
    vectors++; if (bus.rvalid_o !== 1'b1) begin miscompares++; $display("FAIL lane_rvalid got=%b want 1", bus.rvalid_o); end
    vectors++; if (bus.rdata_o !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL lane_rdata got=%h want deadaaef", bus.rdata_o); end
    step();
    vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL lane_rvalid_end got=%b want 0", bus.rvalid_o); end
    vectors++; if (bus.rdata_o !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL lane_rdata_hold got=%h want deadaaef", bus.rdata_o); end
  endtask

  task automatic test_burst_stall();
    logic [31:0] d [16];
    logic [31:0] got [16];
    int ngot, first_k;
    bit contig;
    for (int i = 0; i < 16; i++) d[i] = 32'(i + 1);
    issue_req(32'h200, 4'b1111, 5'd4);
    write_beats(d, 0, 2);
    repeat (2) begin
      vectors++; if (bus.wready_o !== 1'b1) begin miscompares++; $display("FAIL stall_wready got=%b want 1", bus.wready_o); end
      vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_req_ready got=%b want 0", bus.req_ready_o); end
      step();
    end
    write_beats(d, 2, 2);
    read_burst(32'h200, 5'd4, got, ngot, first_k, contig);
    vectors++; if (ngot !== 4) begin miscompares++; $display("FAIL burst_count got=%0d want 4", ngot); end
    vectors++; if (first_k !== RL) begin miscompares++; $display("FAIL burst_latency got=%0d want %0d", first_k, RL); end
    vectors++; if (contig !== 1'b1) begin miscompares++; $display("FAIL burst_contiguous got=%b want 1", contig); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== 32'(i + 1)) begin miscompares++; $display("FAIL burst_beat%0d got=%h want %h", i, got[i], 32'(i + 1)); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d [16];
    logic [31:0] got [16];
    int ngot, first_k;
    bit contig;
    for (int i = 0; i < 16; i++) d[i] = '0;
    d[0] = WORD_A;
    d[1] = WORD_B;
    issue_req(32'hFFFC, 4'b1111, 5'd2);
    write_beats(d, 0, 2);
    read_burst(32'hFFFC, 5'd2, got, ngot, first_k, contig);
    vectors++; if (ngot !== 2) begin miscompares++; $display("FAIL wrap_count got=%0d want 2", ngot); end
    vectors++; if (got[0] !== WORD_A) begin miscompares++; $display("FAIL wrap_beat0 got=%h want %h", got[0], WORD_A); end
    vectors++; if (got[1] !== WORD_B) begin miscompares++; $display("FAIL wrap_beat1 got=%h want %h", got[1], WORD_B); end
    read_burst(32'h0, 5'd1, got, ngot, first_k, contig);
    vectors++; if (got[0] !== WORD_B) begin miscompares++; $display("FAIL wrap_word0 got=%h want %h", got[0], WORD_B); end
  endtask

  task automatic test_errors();
    logic [31:0] e_addr [4];
    logic [4:0]  e_len  [4];
    logic [31:0] got [16];
    int ngot, first_k;
    bit contig;
    e_addr[0] = 32'h102;   e_len[0] = 5'd1;
    e_addr[1] = 32'h10000; e_len[1] = 5'd1;
    e_addr[2] = 32'h100;   e_len[2] = 5'd0;
    e_addr[3] = 32'h100;   e_len[3] = 5'd17;
    for (int i = 0; i < 4; i++) begin
      // Write data offered alongside: a wrongly accepted request would corrupt memory.
      bus.wvalid_i = 1'b1;
      bus.wdata_i  = 32'h1111_1111;
      issue_req(e_addr[i], 4'b1111, e_len[i]);
      vectors++; if (bus.err_o !== 1'b1) begin miscompares++; $display("FAIL err%0d_pulse got=%b want 1", i, bus.err_o); end
      vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL err%0d_ready got=%b want 1", i, bus.req_ready_o); end
      vectors++; if (bus.wready_o !== 1'b0) begin miscompares++; $display("FAIL err%0d_wready got=%b want 0", i, bus.wready_o); end
      step();
      vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL err%0d_pulse_end got=%b want 0", i, bus.err_o); end
    end
    bus.wvalid_i = 1'b0;
    read_burst(32'h100, 5'd1, got, ngot, first_k, contig);
    vectors++; if (got[0] !== 32'hDEAD_AAEF) begin miscompares++; $display("FAIL err_nowrite_100 got=%h want deadaaef", got[0]); end
    read_burst(32'h0, 5'd1, got, ngot, first_k, contig);
    vectors++; if (got[0] !== WORD_B) begin miscompares++; $display("FAIL err_nowrite_0 got=%h want %h", got[0], WORD_B); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] got [16];
    int ngot, first_k, stray;
    bit contig;
    issue_req(32'h200, 4'b0000, 5'd8);
    step();
    step();
    vectors++; if (bus.rvalid_o !== 1'b1) begin miscompares++; $display("FAIL mid_rvalid got=%b want 1", bus.rvalid_o); end
    vectors++; if (bus.rdata_o !== 32'h1) begin miscompares++; $display("FAIL mid_rdata got=%h want 1", bus.rdata_o); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.rvalid_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rvalid got=%b want 0", bus.rvalid_o); end
    vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got=%b want 0", bus.req_ready_o); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready got=%b want 1", bus.req_ready_o); end
    stray = 0;
    repeat (5) begin
      if (bus.rvalid_o !== 1'b0) stray++;
      step();
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL mid_stray_beats got=%0d want 0", stray); end
    read_burst(32'h204, 5'd1, got, ngot, first_k, contig);
    vectors++; if (got[0] !== 32'h2) begin miscompares++; $display("FAIL mid_mem_kept got=%h want 2", got[0]); end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_be_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.wvalid_i    = 1'b0;
    bus.wdata_i     = '0;
    test_reset();
    test_byte_lanes();
    test_burst_stall();
    test_wrap();
    test_errors();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout sim_time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
